// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with selectable op,
// valid/ready handshakes and a DEPTH-entry result FIFO.
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out,
   output logic                     out_zero,
   output logic                     out_parity,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = WIDTH + 2;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("logic_gate_unit: DEPTH must be a power of two >= 2");
   end

   logic [EW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] res;
   logic [EW-1:0]    head;
   logic             push, pop;

   always_comb begin
      res = '0;
      case (in_op)
         3'd0: res = in_a & in_b;
         3'd1: res = in_a | in_b;
         3'd2: res = in_a ^ in_b;
         3'd3: res = ~(in_a ^ in_b);
         3'd4: res = ~(in_a & in_b);
         3'd5: res = ~(in_a | in_b);
         3'd6: res = ~in_a;
         3'd7: res = in_a;
         default: res = '0;
      endcase
   end

   // Handshakes look only at registered occupancy, never at the other side.
   assign in_ready  = (level_q != DEPTH[AW:0]);
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {res, (res == '0), ^res};
   end

   assign head       = out_valid ? mem_q[rptr_q] : '0;
   assign out        = head[EW-1:2];
   assign out_zero   = head[1];
   assign out_parity = head[0];
   assign level      = level_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed scenarios plus a
// randomized run scored against a queue-based reference model.
module tb_logic_gate_unit;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   in_op = '0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out;
   logic         out_zero;
   logic         out_parity;
   logic [2:0]   level;

   int checks = 0;
   int errors = 0;
   logic [W+1:0] q[$];

   logic_gate_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_zero(out_zero), .out_parity(out_parity),
      .level(level)
   );

   always #5 clk = ~clk;

   function automatic logic [W+1:0] ref_entry(
      input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~(a ^ b);
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: r = ~a;
         default: r = a;
      endcase
      return {r, (r == 0), ^r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: check state against model, drive inputs,
   // advance the model across the next rising edge.
   task automatic cyc(input logic v, input logic [2:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy);
      logic [W+1:0] h;
      logic         do_push, do_pop;
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      out_ready = ordy;
      h = (q.size() > 0) ? q[0] : '0;
      chk("level", 32'(level), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() != D));
      chk("out", 32'(out), 32'(h[W+1:2]));
      chk("out_zero", 32'(out_zero), 32'(h[1]));
      chk("out_parity", 32'(out_parity), 32'(h[0]));
      do_push = v && (q.size() < D);
      do_pop  = ordy && (q.size() > 0);
      if (do_pop) h = q.pop_front();
      if (do_push) q.push_back(ref_entry(op, a, b));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic mid_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out", 32'(out), 32'd0);
      rst = 1'b0;
      q.delete();
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] exp_ops [8];
      exp_ops = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3A, 8'hC5};

      #3;
      chk("init_out_valid", 32'(out_valid), 32'd0);
      chk("init_in_ready", 32'(in_ready), 32'd1);
      chk("init_level", 32'(level), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Every op on a fixed operand pair, drained each cycle
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 3'(i), 8'hC5, 8'h3A, 1'b1);
         chk($sformatf("op%0d_out", i), 32'(out), 32'(exp_ops[i]));
         chk($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
         if (i == 0) chk("op0_zero", 32'(out_zero), 32'd1);
         if (i == 7) chk("op7_parity", 32'(out_parity), 32'd0);
      end
      cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Fill to full, ignored fifth push, then drain in order
      for (int i = 1; i <= 4; i++) cyc(1'b1, 3'd7, 8'(i), 8'h00, 1'b0);
      chk("full_level", 32'(level), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      cyc(1'b1, 3'd7, 8'h05, 8'h00, 1'b0);
      chk("full_level_after5", 32'(level), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("drain%0d", i), 32'(out), 32'(i));
         cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
         if (i == 1) chk("in_ready_after_pop", 32'(in_ready), 32'd1);
      end
      chk("drained_valid", 32'(out_valid), 32'd0);

      // Sustained push+pop at level 2
      cyc(1'b1, 3'd7, 8'hA1, 8'h00, 1'b0);
      cyc(1'b1, 3'd7, 8'hA2, 8'h00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 3'd2, 8'($urandom), 8'($urandom), 1'b1);
         chk("steady_level", 32'(level), 32'd2);
      end
      cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Reset mid-burst
      for (int i = 0; i < 3; i++) cyc(1'b1, 3'd1, 8'(i), 8'h10, 1'b0);
      chk("burst_level", 32'(level), 32'd3);
      mid_reset();
      cyc(1'b1, 3'd2, 8'hF0, 8'h0F, 1'b0);
      chk("post_rst_out", 32'(out), 32'hFF);
      chk("post_rst_parity", 32'(out_parity), 32'd0);
      chk("post_rst_zero", 32'(out_zero), 32'd0);
      cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Random traffic
      for (int i = 0; i < 1000; i++)
         cyc(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom));
      for (int i = 0; i < D + 1; i++) cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
